// File: rtl/vga_ctrl_if.sv
// Video bus between the VGA timing generator, the video-memory lookup and the board pins.
// The master side is the timing generator; the slave side is memory plus pin consumer.
interface vga_ctrl_if;
   logic [23:0] vga_data;
   logic [9:0]  h_addr;
   logic [9:0]  v_addr;
   logic        hsync;
   logic        vsync;
   logic        blank_n;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;
   logic        frame_start;

   modport master (
      input  vga_data,
      output h_addr, v_addr, hsync, vsync, blank_n, vga_r, vga_g, vga_b, frame_start
   );

   modport slave (
      output vga_data,
      input  h_addr, v_addr, hsync, vsync, blank_n, vga_r, vga_g, vga_b, frame_start
   );
endinterface

// File: rtl/vga_ctrl.sv
// VGA raster timing generator: free-running h/v counters, combinational pixel address,
// and a single register stage that keeps pixel, sync and blank mutually aligned.
module vga_ctrl #(
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10
) (
   input  logic      clk,
   input  logic      rst,
   vga_ctrl_if.master bus
);

   localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
   localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
   localparam logic [9:0] H_ACT0  = 10'(H_SYNC + H_BP);
   localparam logic [9:0] V_ACT0  = 10'(V_SYNC + V_BP);
   localparam logic [9:0] H_ACT1  = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] V_ACT1  = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [9:0] H_SYNCW = 10'(H_SYNC);
   localparam logic [9:0] V_SYNCW = 10'(V_SYNC);

   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        blank_n_q, blank_n_d;
   logic        frame_start_q, frame_start_d;
   logic [23:0] rgb_q, rgb_d;
   logic        h_vis, v_vis, vis;

   // v_cnt only moves on the edge where h_cnt wraps.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
   end

   always_comb begin
      h_vis = (h_cnt_q >= H_ACT0) && (h_cnt_q < H_ACT1);
      v_vis = (v_cnt_q >= V_ACT0) && (v_cnt_q < V_ACT1);
      vis   = h_vis && v_vis;

      hsync_d       = !(h_cnt_q < H_SYNCW);
      vsync_d       = !(v_cnt_q < V_SYNCW);
      blank_n_d     = vis;
      rgb_d         = vis ? bus.vga_data : 24'h0;
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
   end

   // Reset values mirror the idle pin state: syncs deasserted, picture blanked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
         rgb_q         <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_n_q     <= blank_n_d;
         frame_start_q <= frame_start_d;
         rgb_q         <= rgb_d;
      end
   end

   assign bus.h_addr      = h_vis ? (h_cnt_q - H_ACT0) : 10'd0;
   assign bus.v_addr      = v_vis ? (v_cnt_q - V_ACT0) : 10'd0;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.blank_n     = blank_n_q;
   assign bus.frame_start = frame_start_q;
   assign bus.vga_r       = rgb_q[23:16];
   assign bus.vga_g       = rgb_q[15:8];
   assign bus.vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl on a shrunken raster so whole frames fit in a short run.
// A reference model pushes expected pin states per edge; directed checks cover the boundaries.
module tb_vga_ctrl;

   localparam int HS = 6, HB = 4, HA = 20, HF = 3;
   localparam int VS = 2, VB = 3, VA = 6, VF = 2;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int HA0 = HS + HB;
   localparam int VA0 = VS + VB;
   localparam int FRAME = HT * VT;
   localparam int FIRST_VIS = VA0 * HT + HA0 + 1;
   localparam int LAST_VIS  = (VA0 + VA - 1) * HT + (HA0 + HA - 1) + 1;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        bn;
      logic        fs;
      logic [23:0] rgb;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   vga_ctrl_if bus ();

   vga_ctrl #(
      .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // Video memory stand-in: combinational pattern of the requested address.
   assign bus.vga_data = {bus.h_addr[7:0], bus.v_addr[7:0], 8'hA5};

   always #5 clk = ~clk;

   out_t exp_q[$];
   out_t obs;
   int   m_h, m_v;
   int   edge_n;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic out_t model_out(input int h, input int v);
      out_t o;
      logic vis;
      vis   = (h >= HA0) && (h < HA0 + HA) && (v >= VA0) && (v < VA0 + VA);
      o.hs  = !(h < HS);
      o.vs  = !(v < VS);
      o.bn  = vis;
      o.fs  = (h == 0) && (v == 0);
      o.rgb = vis ? {8'(h - HA0), 8'(v - VA0), 8'hA5} : 24'h0;
      return o;
   endfunction

   function automatic logic [19:0] model_addr(input int h, input int v);
      logic [9:0] ha, va;
      ha = (h >= HA0 && h < HA0 + HA) ? 10'(h - HA0) : 10'd0;
      va = (v >= VA0 && v < VA0 + VA) ? 10'(v - VA0) : 10'd0;
      return {ha, va};
   endfunction

   // One clock: queue the expectation from pre-edge counters, then compare after the edge.
   task automatic tick();
      out_t e;
      exp_q.push_back(model_out(m_h, m_v));
      @(posedge clk);
      edge_n++;
      if (m_h == HT - 1) begin
         m_h = 0;
         m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
         m_h++;
      end
      #1;
      obs = {bus.hsync, bus.vsync, bus.blank_n, bus.frame_start, bus.vga_r, bus.vga_g, bus.vga_b};
      e   = exp_q.pop_front();
      check("pipe", 32'(obs), 32'(e));
      check("addr", 32'({bus.h_addr, bus.v_addr}), 32'(model_addr(m_h, m_v)));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_hsync"}, 32'(bus.hsync), 32'd1);
      check({tag, "_vsync"}, 32'(bus.vsync), 32'd1);
      check({tag, "_blank_n"}, 32'(bus.blank_n), 32'd0);
      check({tag, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
      check({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
      check({tag, "_addr"}, 32'({bus.h_addr, bus.v_addr}), 32'd0);
   endtask

   initial begin
      int hs_low, vs_low, first_hs_high, first_vis, fs_cnt, found;
      int fs_edge[$];

      // Reset held: pins at idle values.
      #12;
      check_reset_state("reset");

      @(negedge clk);
      rst = 1'b0;
      m_h = 0; m_v = 0; edge_n = 0;
      hs_low = 0; vs_low = 0; first_hs_high = 0; first_vis = 0; fs_cnt = 0;

      for (int i = 0; i < 2 * FRAME + 5; i++) begin
         tick();
         if (edge_n <= HT && !obs.hs) hs_low++;
         if (edge_n <= HT && obs.hs && first_hs_high == 0) first_hs_high = edge_n;
         if (edge_n <= FRAME && !obs.vs) vs_low++;
         if (obs.bn && first_vis == 0) first_vis = edge_n;
         if (obs.fs) begin
            fs_cnt++;
            fs_edge.push_back(edge_n);
         end
         if (edge_n == 1) check("fs_edge1", 32'(obs.fs), 32'd1);
         if (edge_n == 2) check("fs_edge2", 32'(obs.fs), 32'd0);
         if (edge_n == FIRST_VIS) check("first_pix", 32'({obs.bn, obs.rgb}), {8'd0, 1'b1, 24'h0000A5});
         if (edge_n == LAST_VIS)
            check("last_pix", 32'({obs.bn, obs.rgb}), {7'd0, 1'b1, 8'(HA - 1), 8'(VA - 1), 8'hA5});
         if (edge_n == LAST_VIS + 1) check("after_last", 32'({obs.bn, obs.rgb}), 32'd0);
      end
      check("hsync_low_clocks", 32'(hs_low), 32'(HS));
      check("hsync_first_high", 32'(first_hs_high), 32'(HS + 1));
      check("vsync_low_clocks", 32'(vs_low), 32'(VS * HT));
      check("first_vis_edge", 32'(first_vis), 32'(FIRST_VIS));
      check("frame_start_count", 32'(fs_cnt), 32'd3);
      if (fs_edge.size() >= 2)
         check("frame_period", 32'(fs_edge[1] - fs_edge[0]), 32'(FRAME));
      else
         check("frame_period_seen", 32'(fs_edge.size()), 32'd2);

      // Advance to a mid-frame position, then hit reset between edges.
      found = 0;
      for (int i = 0; i < FRAME && found == 0; i++) begin
         if (m_h == 15 && m_v == 8) found = 1;
         else tick();
      end
      check("midframe_reached", 32'(found), 32'd1);
      #3;
      rst = 1'b1;
      #2;
      check_reset_state("midrst");

      @(negedge clk);
      rst = 1'b0;
      m_h = 0; m_v = 0; edge_n = 0;
      hs_low = 0; first_vis = 0;
      for (int i = 0; i < FIRST_VIS + 5; i++) begin
         tick();
         if (edge_n <= HT && !obs.hs) hs_low++;
         if (obs.bn && first_vis == 0) first_vis = edge_n;
         if (edge_n == 1) check("midrst_fs_edge1", 32'(obs.fs), 32'd1);
      end
      check("midrst_hsync_low", 32'(hs_low), 32'(HS));
      check("midrst_first_vis", 32'(first_vis), 32'(FIRST_VIS));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
